ipsl_pcie_dma_mrd_sched: RTL
============================

Name: ipsl_pcie_dma_mrd_sched

Overview:
DMA read scheduler for the PCIe DMA controller. It accepts one DMA read command (start address and length in DW) and splits it into MRd TLP requests toward the TX top. Each request honours the configured max read request size and never crosses a 4 KB boundary. It allocates a tag per request, releases tags as completions arrive from RX, and signals done when every tag of the command has been released.

Parameters:
TAG_NUM, 32, number of tags managed (tags 0..TAG_NUM-1, TAG_NUM ≤ 256, power of 2)
CMD_LEN_W, 16, width of the command DW-length field

Ports:
clk  in  1  core clock (gen1 62.5 MHz, gen2 125 MHz)
rst  in  1  synchronous reset, active-high
i_cfg_max_rd_req_size  in  3  MRRS code (0=128 B .. 5=4096 B; 6,7 treated as 5)
i_cmd_vld  in  1  command valid
o_cmd_rdy  out  1  command ready
i_cmd_addr  in  64  start byte address, DW aligned (bits[1:0] ignored, treated 0)
i_cmd_len_dw  in  CMD_LEN_W  total DW to read
o_mrd_req_vld  out  1  MRd request valid
i_mrd_req_rdy  in  1  TX accepts request
o_mrd_addr  out  64  request address
o_mrd_length  out  10  request DW length (1024 encoded as 0)
o_mrd_tag  out  8  allocated tag
i_tag_full  in  1  external stall (TX tag/credit full)
i_cpld_rcv  in  1  final completion for a tag received (pulse)
i_cpld_tag  in  8  tag of that completion
o_busy  out  1  command in progress
o_done  out  1  one-cycle pulse, command fully completed
o_outstanding  out  $clog2(TAG_NUM)+1  tags currently in use
o_tag_err  out  1  sticky: release of a free or out-of-range tag

Behaviour:
- Reset: o_cmd_rdy=1, o_mrd_req_vld=0, o_mrd_addr=0, o_mrd_length=0, o_mrd_tag=0, o_busy=0, o_done=0, o_outstanding=0, o_tag_err=0. All tags free, state IDLE.
- A reset asserted mid-operation aborts the command. o_mrd_req_vld drops at the reset edge. Late completions after reset count as free-tag releases and set o_tag_err.
- States: IDLE, CALC, REQ, WAIT_CPL.
- IDLE: o_cmd_rdy=1. On i_cmd_vld&&o_cmd_rdy, latch addr, len and MRRS code.
  - len==0: o_done pulses the next cycle; stay in IDLE.
  - otherwise: go to CALC with o_busy=1.
- CALC (1 cycle): registered chunk = min(rem, mrrs_dw, 1024-addr[11:2]), where mrrs_dw = 32<<min(code,5). Arithmetic is 11-bit unsigned. Next state is REQ.
- REQ:
  - o_mrd_req_vld=1 only while a tag is free and i_tag_full=0. Tag = lowest-index free tag.
  - addr, length and tag stay stable while vld=1 && rdy=0. vld may drop if i_tag_full rises before handshake; the tag is then re-evaluated.
  - On handshake: mark the tag busy, addr += chunk<<2, rem -= chunk. Go to WAIT_CPL if rem==0, else CALC.
  - Latency from command accept to first vld is 2 cycles. Back-to-back requests issue every 2 cycles.
- WAIT_CPL: when o_outstanding==0 (including a release in the same cycle), pulse o_done and go to IDLE with o_busy=0.
- Tag release (i_cpld_rcv, any state): clears the busy bit. A release and an allocation in the same cycle are both applied, and o_outstanding nets to unchanged. A free or ≥TAG_NUM tag sets o_tag_err and changes nothing.
- All tags busy: REQ holds vld=0 until a release. The released tag is offered the cycle after the release.
- Length encoding: chunk==1024 drives o_mrd_length=10'd0.
- Address increment carries across all 64 bits. Wrap at 2^64 is not checked.

Decomposition:
- Package ipsl_pcie_dma_mrd_pkg holds:
  - state encoding (IDLE/CALC/REQ/WAIT_CPL)
  - MRRS code limit (5) and DW_PER_4K=1024
  - a function mrrs_to_dw(code)
- One sub-module, ipsl_pcie_dma_tag_pool:
  - TAG_NUM-bit busy bitmap
  - lowest-free priority encoder (tag + any_free)
  - alloc/release ports, outstanding counter, error flag

Test Plan:
1. MRRS=0 (128 B), addr=0x1000, len=96 DW -> 3 requests of 32 DW at 0x1000/0x1080/0x1100 with tags 0,1,2; release 2,0,1 -> o_done pulses one cycle after the last release.
2. addr=0x0FF0, len=8 DW, MRRS=2 -> 4 DW @0x0FF0 then 4 DW @0x1000 (4 KB split).
3. MRRS=5, addr=0x2000, len=1024 DW -> one request, o_mrd_length=0; MRRS code 7 behaves identically.
4. TAG_NUM=4, len=256 DW, MRRS=0, no releases -> 4 requests, then vld=0 with o_outstanding=4; release tag 2 -> next request uses tag 2; hold i_mrd_req_rdy=0 for 5 cycles -> outputs stable.
5. len=0 -> o_done 1 cycle after accept, no request issued. Release of free tag 5 -> o_tag_err=1 and stays set until reset.
6. Assert rst during REQ with 2 tags outstanding -> next cycle all outputs at reset values, o_cmd_rdy=1, o_outstanding=0.

Source files
------------

// File: rtl/ipsl_pcie_dma_mrd_pkg.sv
// Shared constants and helpers for the PCIe DMA read scheduler.
package ipsl_pcie_dma_mrd_pkg;

   // Scheduler state encoding, kept as plain constants for legacy compatibility.
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_CALC     = 2'd1;
   localparam logic [1:0] ST_REQ      = 2'd2;
   localparam logic [1:0] ST_WAIT_CPL = 2'd3;

   // MRRS codes above 5 (4096 B) saturate to 5.
   localparam logic [2:0] MRRS_CODE_MAX = 3'd5;

   // DWs in one 4 KB page; also the largest encodable MRd length.
   localparam int unsigned DW_PER_4K = 1024;

   // MRRS code to DW count: 32 DW (128 B) shifted by the saturated code.
   function automatic logic [10:0] mrrs_to_dw(input logic [2:0] code);
      logic [2:0] c;
      c = (code > MRRS_CODE_MAX) ? MRRS_CODE_MAX : code;
      return 11'd32 << c;
   endfunction

endpackage

// File: rtl/ipsl_pcie_dma_tag_pool.sv
// Tag pool: busy bitmap, lowest-free encoder, outstanding counter, sticky release error.
module ipsl_pcie_dma_tag_pool #(
   parameter int unsigned TAG_NUM = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         alloc_en,
   output logic [7:0]                   free_tag,
   output logic                         any_free,
   input  logic                         rel_en,
   input  logic [7:0]                   rel_tag,
   output logic [$clog2(TAG_NUM):0]     outstanding,
   output logic [$clog2(TAG_NUM):0]     outstanding_nxt,
   output logic                         tag_err
);

   localparam int unsigned TW = $clog2(TAG_NUM);
   localparam int unsigned CW = TW + 1;

   logic [TAG_NUM-1:0] busy_q;
   logic [TAG_NUM-1:0] busy_nxt;
   logic [TAG_NUM-1:0] alloc_mask;
   logic [TAG_NUM-1:0] rel_mask;
   logic [CW-1:0]      cnt_q;
   logic               err_q;
   logic               rel_in_range;
   logic               rel_hit;
   logic               alloc_do;

   // Lowest-index free tag: scan downwards so the smallest free index wins.
   always_comb begin
      free_tag = '0;
      any_free = 1'b0;
      for (int unsigned i = TAG_NUM; i > 0; i--) begin
         if (!busy_q[i-1]) begin
            free_tag = 8'(i - 1);
            any_free = 1'b1;
         end
      end
   end

   // Allocation and release are applied together; a bad release changes nothing.
   always_comb begin
      rel_in_range = ({1'b0, rel_tag} < 9'(TAG_NUM));
      rel_hit      = rel_en && rel_in_range && busy_q[rel_tag[TW-1:0]];
      alloc_do     = alloc_en && any_free;
      alloc_mask   = '0;
      rel_mask     = '0;
      if (alloc_do) begin
         alloc_mask[free_tag[TW-1:0]] = 1'b1;
      end
      if (rel_hit) begin
         rel_mask[rel_tag[TW-1:0]] = 1'b1;
      end
      busy_nxt        = (busy_q | alloc_mask) & ~rel_mask;
      outstanding_nxt = cnt_q + CW'(alloc_do) - CW'(rel_hit);
   end

   // Bitmap, counter and sticky error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_nxt;
         cnt_q  <= outstanding_nxt;
         if (rel_en && !rel_hit) begin
            err_q <= 1'b1;
         end
      end
   end

   assign outstanding = cnt_q;
   assign tag_err     = err_q;

endmodule

// File: rtl/ipsl_pcie_dma_mrd_sched.sv
// DMA read scheduler: splits one read command into MRRS/4KB-bounded MRd requests with tags.
module ipsl_pcie_dma_mrd_sched #(
   parameter int unsigned TAG_NUM   = 32,
   parameter int unsigned CMD_LEN_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [2:0]                 i_cfg_max_rd_req_size,
   input  logic                       i_cmd_vld,
   output logic                       o_cmd_rdy,
   input  logic [63:0]                i_cmd_addr,
   input  logic [CMD_LEN_W-1:0]       i_cmd_len_dw,
   output logic                       o_mrd_req_vld,
   input  logic                       i_mrd_req_rdy,
   output logic [63:0]                o_mrd_addr,
   output logic [9:0]                 o_mrd_length,
   output logic [7:0]                 o_mrd_tag,
   input  logic                       i_tag_full,
   input  logic                       i_cpld_rcv,
   input  logic [7:0]                 i_cpld_tag,
   output logic                       o_busy,
   output logic                       o_done,
   output logic [$clog2(TAG_NUM):0]   o_outstanding,
   output logic                       o_tag_err
);

   import ipsl_pcie_dma_mrd_pkg::*;

   localparam int unsigned CW = $clog2(TAG_NUM) + 1;

   logic [1:0]           state_q;
   logic [63:0]          addr_q;
   logic [CMD_LEN_W-1:0] rem_q;
   logic [2:0]           code_q;
   logic [10:0]          chunk_q;
   logic                 done_q;

   logic [10:0]          rem_cap;
   logic [10:0]          mrrs_dw;
   logic [10:0]          bnd_dw;
   logic [10:0]          chunk_calc;

   logic [7:0]           free_tag;
   logic                 any_free;
   logic                 mrd_fire;
   logic [CW-1:0]        outstanding_nxt;

   ipsl_pcie_dma_tag_pool #(
      .TAG_NUM (TAG_NUM)
   ) u_tag_pool (
      .clk             (clk),
      .rst             (rst),
      .alloc_en        (mrd_fire),
      .free_tag        (free_tag),
      .any_free        (any_free),
      .rel_en          (i_cpld_rcv),
      .rel_tag         (i_cpld_tag),
      .outstanding     (o_outstanding),
      .outstanding_nxt (outstanding_nxt),
      .tag_err         (o_tag_err)
   );

   // Next chunk size: min of remaining DW, MRRS in DW and DW left before the 4 KB page end.
   always_comb begin
      rem_cap    = (32'(rem_q) > 32'(DW_PER_4K)) ? 11'(DW_PER_4K) : 11'(rem_q);
      mrrs_dw    = mrrs_to_dw(code_q);
      bnd_dw     = 11'(DW_PER_4K) - {1'b0, addr_q[11:2]};
      chunk_calc = rem_cap;
      if (mrrs_dw < chunk_calc) begin
         chunk_calc = mrrs_dw;
      end
      if (bnd_dw < chunk_calc) begin
         chunk_calc = bnd_dw;
      end
   end

   assign o_cmd_rdy     = (state_q == ST_IDLE);
   assign o_busy        = (state_q != ST_IDLE);
   assign o_mrd_req_vld = (state_q == ST_REQ) && any_free && !i_tag_full;
   assign mrd_fire      = o_mrd_req_vld && i_mrd_req_rdy;
   assign o_mrd_addr    = addr_q;
   assign o_mrd_length  = chunk_q[9:0];
   assign o_mrd_tag     = free_tag;
   assign o_done        = done_q;

   // Command sequencing: accept, compute chunk, issue request, drain completions.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         code_q  <= '0;
         chunk_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_cmd_vld) begin
                  addr_q <= i_cmd_addr & ~64'h3;
                  rem_q  <= i_cmd_len_dw;
                  code_q <= i_cfg_max_rd_req_size;
                  if (i_cmd_len_dw == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               chunk_q <= chunk_calc;
               state_q <= ST_REQ;
            end
            ST_REQ: begin
               if (mrd_fire) begin
                  addr_q <= addr_q + (64'(chunk_q) << 2);
                  rem_q  <= rem_q - CMD_LEN_W'(chunk_q);
                  if (rem_q == CMD_LEN_W'(chunk_q)) begin
                     state_q <= ST_WAIT_CPL;
                  end else begin
                     state_q <= ST_CALC;
                  end
               end
            end
            ST_WAIT_CPL: begin
               // Uses the post-release count so a release this cycle finishes immediately.
               if (outstanding_nxt == '0) begin
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
